// File: rtl/ysyx_22040088_ifu.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from instruction
// memory and hands {pc, inst} to decode; execute-side redirects discard stale fetches.
module ysyx_22040088_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_misalign
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic        drop;
    logic        drop_next;
    logic        misalign;
    logic        capture;
    logic        req_fire;

    assign imem_req_valid = (state == S_REQ) && !misalign && !rst;
    assign imem_addr      = pc;
    assign if_valid       = (state == S_HOLD);
    assign if_misalign    = misalign;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            misalign <= 1'b0;
            if_pc    <= 64'h0;
            if_inst  <= 32'h0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            drop     <= drop_next;
            misalign <= (pc_next[1:0] != 2'b00);
            if (capture) begin
                if_pc   <= pc;
                if_inst <= imem_resp_data;
            end
        end
    end

    // Redirect always wins; a fetch already accepted by memory must still be drained.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        capture    = 1'b0;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
                if (req_fire) begin
                    state_next = S_WAIT;
                    if (redirect_valid) begin
                        drop_next = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                    if (imem_resp_valid) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    drop_next = 1'b0;
                    if (drop) begin
                        state_next = S_REQ;
                    end else begin
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = S_REQ;
                end else if (if_ready) begin
                    pc_next    = pc + 64'd4;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Self-checking bench for ysyx_22040088_ifu: a latency-programmable memory model,
// a decode-side scoreboard, table-driven fetches and directed redirect/misalign cases.
module tb_ysyx_22040088_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_misalign;

    ysyx_22040088_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_misalign     (if_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } sb_entry_t;

    typedef struct {
        logic [63:0] pc;
        int          lat;
        int          stall;
    } vec_t;

    sb_entry_t   sb[$];
    vec_t        vecs[4];
    int          checks = 0;
    int          passes = 0;
    int          mem_lat = 1;
    logic        pend = 1'b0;
    logic [63:0] paddr = 64'h0;
    int          cnt = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 32'h0000_0413;
        return a[31:0] ^ 32'h1357_9BDF ^ {a[63:48], 16'h0};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rr, input logic dr);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rr;
        if_ready       = dr;
        @(posedge clk);
        #1;
    endtask

    // Memory: one response per accepted request, mem_lat cycles after acceptance.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = mem_lat;
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(paddr);
                    pend            = 1'b0;
                end
            end
        end
    end

    // Decode side: every accepted instruction must match the next scoreboard entry.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && if_valid && if_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL sb_underflow: got pc %h expected no instruction", if_pc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_pc", if_pc, e.pc);
                    checkOutput("sb_inst", {32'h0, if_inst}, {32'h0, e.inst});
                end
            end
        end
    end

    task automatic fetchOne(input logic [63:0] exp_pc, input int lat, input int stall);
        sb_entry_t e;
        int n;
        mem_lat = lat;
        checkOutput("req_addr", imem_addr, exp_pc);
        e.pc   = exp_pc;
        e.inst = mem_word(exp_pc);
        sb.push_back(e);
        n = 0;
        while (!if_valid && n < 20) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
            n++;
        end
        if (!if_valid) begin
            checks++;
            $display("[TB] FAIL valid_timeout: got no if_valid after %0d cycles required %0d", n, lat + 1);
        end else begin
            checkOutput("latency", 64'(n), 64'(lat + 1));
        end
        for (int s = 0; s < stall; s++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
            checkOutput("hold_valid", {63'h0, if_valid}, 64'h1);
            checkOutput("hold_pc", if_pc, exp_pc);
            checkOutput("hold_inst", {32'h0, if_inst}, {32'h0, mem_word(exp_pc)});
            checkOutput("hold_noreq", {63'h0, imem_req_valid}, 64'h0);
        end
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("post_fire_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("next_addr", imem_addr, exp_pc + 64'd4);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{pc: 64'h0000_0000_8000_0000, lat: 1, stall: 0};
        vecs[1] = '{pc: 64'h0000_0000_8000_0004, lat: 3, stall: 5};
        vecs[2] = '{pc: 64'h0000_0000_0000_0000, lat: 2, stall: 1};
        vecs[3] = '{pc: 64'h0000_0000_0000_0004, lat: 1, stall: 2};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_if_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("rst_if_inst", {32'h0, if_inst}, 64'h0);
        checkOutput("rst_misalign", {63'h0, if_misalign}, 64'h0);
        checkOutput("rst_addr", imem_addr, 64'h0000_0000_8000_0000);
        rst = 1'b0;
        #1;
        checkOutput("first_req_valid", {63'h0, imem_req_valid}, 64'h1);

        for (int i = 0; i < 2; i++) fetchOne(vecs[i].pc, vecs[i].lat, vecs[i].stall);

        // Memory back-pressure: request held with a stable address.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
            checkOutput("bp_req_valid", {63'h0, imem_req_valid}, 64'h1);
            checkOutput("bp_addr", imem_addr, 64'h0000_0000_8000_0008);
            checkOutput("bp_if_valid", {63'h0, if_valid}, 64'h0);
        end
        begin
            sb_entry_t e;
            int n;
            mem_lat = 1;
            e.pc   = 64'h0000_0000_8000_0008;
            e.inst = mem_word(e.pc);
            sb.push_back(e);
            n = 0;
            while (!if_valid && n < 20) begin
                applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
                n++;
            end
            checkOutput("bp_latency", 64'(n), 64'd2);
        end

        // Redirect coincident with decode accepting: the target wins over pc+4.
        applyStimulus(1'b1, 64'h0000_0000_8000_0200, 1'b1, 1'b1);
        checkOutput("hold_redir_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("hold_redir_addr", imem_addr, 64'h0000_0000_8000_0200);
        checkOutput("hold_redir_req", {63'h0, imem_req_valid}, 64'h1);

        // Redirect while waiting: the stale response must never reach decode.
        mem_lat = 3;
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
        applyStimulus(1'b1, 64'h0000_0000_8000_0100, 1'b1, 1'b0);
        checkOutput("wait_redir_valid", {63'h0, if_valid}, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("stale_valid_a", {63'h0, if_valid}, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("stale_valid_b", {63'h0, if_valid}, 64'h0);
        checkOutput("stale_next_addr", imem_addr, 64'h0000_0000_8000_0100);
        checkOutput("stale_next_req", {63'h0, imem_req_valid}, 64'h1);
        fetchOne(64'h0000_0000_8000_0100, 1, 0);

        // Redirect in the same cycle a request is accepted: that response is dropped.
        applyStimulus(1'b1, 64'h0000_0000_8000_0300, 1'b1, 1'b0);
        checkOutput("reqfire_redir_req", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("reqfire_redir_addr", imem_addr, 64'h0000_0000_8000_0300);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("reqfire_drop_valid", {63'h0, if_valid}, 64'h0);
        checkOutput("reqfire_drop_req", {63'h0, imem_req_valid}, 64'h1);
        fetchOne(64'h0000_0000_8000_0300, 1, 0);

        // Misaligned redirect suppresses fetching until an aligned redirect.
        applyStimulus(1'b1, 64'h0000_0000_8000_0102, 1'b0, 1'b0);
        checkOutput("mis_flag", {63'h0, if_misalign}, 64'h1);
        checkOutput("mis_addr", imem_addr, 64'h0000_0000_8000_0102);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
            checkOutput("mis_noreq", {63'h0, imem_req_valid}, 64'h0);
            checkOutput("mis_sticky", {63'h0, if_misalign}, 64'h1);
        end
        applyStimulus(1'b1, 64'h0000_0000_8000_0104, 1'b1, 1'b0);
        checkOutput("mis_clear", {63'h0, if_misalign}, 64'h0);
        checkOutput("mis_resume_req", {63'h0, imem_req_valid}, 64'h1);
        fetchOne(64'h0000_0000_8000_0104, 1, 0);

        // PC increment wraps at the top of the address space.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        fetchOne(64'hFFFF_FFFF_FFFF_FFFC, 1, 0);

        for (int i = 2; i < 4; i++) fetchOne(vecs[i].pc, vecs[i].lat, vecs[i].stall);

        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
